// File: rtl/cpu_mem_request_pkg.sv
// Shared definitions for the memory-access stage: FSM states, byte-lane
// mask encodings and a helper that sizes the timeout counter.
package cpu_mem_request_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } memState_t;

    localparam logic [1:0] MASK_WORD = 2'b11;
    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;

    // Smallest counter width able to hold every value up to the limit.
    function automatic int timeoutCounterWidth(input int limit);
        if (limit < 2) begin
            return 1;
        end
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/cpu_mem_request_if.sv
// CPU data-bus signals between the memory-access stage (master) and
// the memory system (slave).
interface cpu_mem_request_if #(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 16
);
    logic                    bus_valid;
    logic                    bus_wr;
    logic [ADDRESS_BITS-1:0] bus_addr;
    logic [BITS-1:0]         bus_wdata;
    logic [1:0]              bus_wr_mask;
    logic                    bus_ready;
    logic                    bus_rvalid;
    logic [BITS-1:0]         bus_rdata;

    modport master (
        output bus_valid, bus_wr, bus_addr, bus_wdata, bus_wr_mask,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_wr, bus_addr, bus_wdata, bus_wr_mask,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/cpu_mem_request_load_formatter.sv
// Byte-lane extraction and zero/sign extension of load data.
module cpu_load_formatter
    import cpu_mem_request_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic [BITS-1:0] rdata_i,
    input  logic [1:0]      mask_i,
    input  logic            sx_i,
    output logic [BITS-1:0] result_o
);

    logic [7:0] laneByte;

    // Pick the addressed byte lane, then widen it; word loads pass straight through.
    always_comb begin
        laneByte = (mask_i == MASK_HI) ? rdata_i[15:8] : rdata_i[7:0];
        if ((mask_i == MASK_LO) || (mask_i == MASK_HI)) begin
            result_o = {{(BITS-8){sx_i & laneByte[7]}}, laneByte};
        end else begin
            result_o = rdata_i;
        end
    end

endmodule

// File: rtl/cpu_mem_request.sv
// Memory-access stage: latches a load/store from execute, runs the bus
// handshake, formats load data for writeback and stalls while busy.
module cpu_mem_request
    import cpu_mem_request_pkg::*;
#(
    parameter int BITS           = 16,
    parameter int ADDRESS_BITS   = 16,
    parameter int REGISTER_BITS  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     load_memory,
    input  logic                     store_memory,
    input  logic [ADDRESS_BITS-1:0]  load_store_address,
    input  logic [BITS-1:0]          memory_out,
    input  logic [1:0]               memory_wr_mask,
    input  logic                     load_sx,
    input  logic [REGISTER_BITS-1:0] dest_reg,
    cpu_mem_request_if.master        bus,
    output logic                     wb_valid,
    output logic [REGISTER_BITS-1:0] wb_reg,
    output logic [BITS-1:0]          wb_data,
    output logic                     stall,
    output logic                     bus_error
);

    localparam int CNT_W = timeoutCounterWidth(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    memState_t               state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic                    wr_q,      wr_d;
    logic [ADDRESS_BITS-1:0] addr_q,    addr_d;
    logic [BITS-1:0]         wdata_q,   wdata_d;
    logic [1:0]              mask_q,    mask_d;
    logic                    sx_q,      sx_d;
    logic [REGISTER_BITS-1:0] dreg_q,   dreg_d;
    logic                    wbValid_q, wbValid_d;
    logic [REGISTER_BITS-1:0] wbReg_q,  wbReg_d;
    logic [BITS-1:0]         wbData_q,  wbData_d;
    logic                    busError_q, busError_d;
    logic                    timeoutHit;
    logic [BITS-1:0]         formatted;

    cpu_load_formatter #(.BITS(BITS)) uFormatter (
        .rdata_i  (bus.bus_rdata),
        .mask_i   (mask_q),
        .sx_i     (sx_q),
        .result_o (formatted)
    );

    // Next-state logic: capture in IDLE, handshake in REQ, collect data in
    // WAIT_RD; the counter expiring on its last allowed cycle aborts the access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        sx_d       = sx_q;
        dreg_d     = dreg_q;
        wbValid_d  = 1'b0;
        wbReg_d    = wbReg_q;
        wbData_d   = wbData_q;
        busError_d = 1'b0;
        timeoutHit = TIMEOUT_EN && (cnt_q == CNT_LIMIT);
        case (state_q)
            IDLE: begin
                if (store_memory || load_memory) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    wr_d    = store_memory;
                    addr_d  = load_store_address;
                    wdata_d = memory_out;
                    mask_d  = memory_wr_mask;
                    sx_d    = load_sx;
                    dreg_d  = dest_reg;
                end
            end
            REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.bus_ready) begin
                    cnt_d   = '0;
                    state_d = wr_q ? IDLE : WAIT_RD;
                end else if (timeoutHit) begin
                    state_d    = IDLE;
                    busError_d = 1'b1;
                    if (!wr_q) begin
                        wbValid_d = 1'b1;
                        wbReg_d   = dreg_q;
                        wbData_d  = '0;
                    end
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.bus_rvalid) begin
                    state_d   = IDLE;
                    wbValid_d = 1'b1;
                    wbReg_d   = dreg_q;
                    wbData_d  = formatted;
                end else if (timeoutHit) begin
                    state_d    = IDLE;
                    busError_d = 1'b1;
                    wbValid_d  = 1'b1;
                    wbReg_d    = dreg_q;
                    wbData_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers; reset aborts any access in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= MASK_WORD;
            sx_q       <= 1'b0;
            dreg_q     <= '0;
            wbValid_q  <= 1'b0;
            wbReg_q    <= '0;
            wbData_q   <= '0;
            busError_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            sx_q       <= sx_d;
            dreg_q     <= dreg_d;
            wbValid_q  <= wbValid_d;
            wbReg_q    <= wbReg_d;
            wbData_q   <= wbData_d;
            busError_q <= busError_d;
        end
    end

    assign bus.bus_valid   = (state_q == REQ);
    assign bus.bus_wr      = wr_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_wdata   = wdata_q;
    assign bus.bus_wr_mask = mask_q;

    assign wb_valid  = wbValid_q;
    assign wb_reg    = wbReg_q;
    assign wb_data   = wbData_q;
    assign bus_error = busError_q;
    assign stall     = (state_q != IDLE) | load_memory | store_memory;

endmodule

// File: tb/tb_cpu_mem_request.sv
// Directed bench for cpu_mem_request with a scoreboard of expected bus
// requests and writebacks, checked by a negedge monitor.
module tb_cpu_mem_request;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  mask;
    } busExp_t;

    typedef struct {
        logic [3:0]  dreg;
        logic [15:0] data;
    } wbExp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        load_memory;
    logic        store_memory;
    logic [15:0] load_store_address;
    logic [15:0] memory_out;
    logic [1:0]  memory_wr_mask;
    logic        load_sx;
    logic [3:0]  dest_reg;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        stall;
    logic        bus_error;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    logic errExpected = 1'b0;
    busExp_t expBus[$];
    wbExp_t  expWb[$];

    cpu_mem_request_if #(.BITS(16), .ADDRESS_BITS(16)) busIf ();

    cpu_mem_request #(
        .BITS(16), .ADDRESS_BITS(16), .REGISTER_BITS(4), .TIMEOUT_CYCLES(4)
    ) dut (
        .CLK(CLK), .RST(RST),
        .load_memory(load_memory), .store_memory(store_memory),
        .load_store_address(load_store_address), .memory_out(memory_out),
        .memory_wr_mask(memory_wr_mask), .load_sx(load_sx), .dest_reg(dest_reg),
        .bus(busIf),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .stall(stall), .bus_error(bus_error)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ld, input logic [15:0] addr,
                                 input logic [15:0] data, input logic [1:0] mask,
                                 input logic sx, input logic [3:0] dreg);
        store_memory       = st;
        load_memory        = ld;
        load_store_address = addr;
        memory_out         = data;
        memory_wr_mask     = mask;
        load_sx            = sx;
        dest_reg           = dreg;
    endtask

    task automatic clearRequest();
        store_memory = 1'b0;
        load_memory  = 1'b0;
    endtask

    // Store (optionally with load also raised) with readyWait wait states.
    task automatic storeOp(input logic alsoLoad, input logic [15:0] addr,
                           input logic [15:0] data, input logic [1:0] mask, input int readyWait);
        busExp_t e;
        applyStimulus(1'b1, alsoLoad, addr, data, mask, 1'b0, 4'd2);
        @(posedge CLK); #1;
        clearRequest();
        e.wr = 1'b1; e.addr = addr; e.wdata = data; e.mask = mask;
        expBus.push_back(e);
        checkOutput("storeValid", busIf.bus_valid, 1);
        for (int i = 0; i < readyWait; i++) begin
            checkOutput("storeStallWait", stall, 1);
            @(posedge CLK); #1;
        end
        busIf.bus_ready = 1'b1;
        @(posedge CLK); #1;
        busIf.bus_ready = 1'b0;
        checkOutput("storeValidDone", busIf.bus_valid, 0);
        checkOutput("storeStallDone", stall, 0);
        checkOutput("storeNoWb", wb_valid, 0);
    endtask

    // Load with readyWait / rvalidWait wait states and a bench-supplied result.
    task automatic loadOp(input logic [15:0] addr, input logic [1:0] mask, input logic sx,
                          input logic [3:0] dreg, input logic [15:0] rdata,
                          input logic [15:0] expData, input int readyWait, input int rvalidWait);
        busExp_t e;
        wbExp_t  w;
        applyStimulus(1'b0, 1'b1, addr, 16'h0000, mask, sx, dreg);
        @(posedge CLK); #1;
        clearRequest();
        e.wr = 1'b0; e.addr = addr; e.wdata = 16'h0000; e.mask = mask;
        expBus.push_back(e);
        for (int i = 0; i < readyWait; i++) begin
            checkOutput("ldReqStall", stall, 1);
            checkOutput("ldReqValid", busIf.bus_valid, 1);
            @(posedge CLK); #1;
        end
        busIf.bus_ready = 1'b1;
        @(posedge CLK); #1;
        busIf.bus_ready = 1'b0;
        for (int i = 0; i < rvalidWait; i++) begin
            checkOutput("ldWaitStall", stall, 1);
            checkOutput("ldWaitValid", busIf.bus_valid, 0);
            @(posedge CLK); #1;
        end
        busIf.bus_rdata  = rdata;
        busIf.bus_rvalid = 1'b1;
        w.dreg = dreg; w.data = expData;
        expWb.push_back(w);
        @(posedge CLK); #1;
        busIf.bus_rvalid = 1'b0;
        checkOutput("ldWbValid", wb_valid, 1);
        checkOutput("ldWbData", wb_data, expData);
        checkOutput("ldWbReg", wb_reg, dreg);
        checkOutput("ldStallDone", stall, 0);
    endtask

    // Scoreboard monitor: pops expectations as handshakes and writebacks appear.
    always @(negedge CLK) begin
        if (!RST && busIf.bus_valid && busIf.bus_ready) begin
            checkOutput("busExpected", (expBus.size() > 0), 1);
            if (expBus.size() > 0) begin
                busExp_t e;
                e = expBus.pop_front();
                checkOutput("busWr", busIf.bus_wr, e.wr);
                checkOutput("busAddr", busIf.bus_addr, e.addr);
                checkOutput("busMask", busIf.bus_wr_mask, e.mask);
                if (e.wr) checkOutput("busWdata", busIf.bus_wdata, e.wdata);
            end
        end
        if (wb_valid) begin
            checkOutput("wbExpected", (expWb.size() > 0), 1);
            if (expWb.size() > 0) begin
                wbExp_t w;
                w = expWb.pop_front();
                checkOutput("sbWbReg", wb_reg, w.dreg);
                checkOutput("sbWbData", wb_data, w.data);
            end
        end
        if (bus_error || errExpected) begin
            checkOutput("busErrorPulse", bus_error, errExpected);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1;
        int t2;
        wbExp_t w;
        busExp_t e;
        RST = 1'b1;
        clearRequest();
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 2'b11, 1'b0, 4'd0);
        busIf.bus_ready  = 1'b0;
        busIf.bus_rvalid = 1'b0;
        busIf.bus_rdata  = 16'h0000;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("rstValid", busIf.bus_valid, 0);
        checkOutput("rstWr", busIf.bus_wr, 0);
        checkOutput("rstAddr", busIf.bus_addr, 0);
        checkOutput("rstWdata", busIf.bus_wdata, 0);
        checkOutput("rstMask", busIf.bus_wr_mask, 2'b11);
        checkOutput("rstWbValid", wb_valid, 0);
        checkOutput("rstWbData", wb_data, 0);
        checkOutput("rstWbReg", wb_reg, 0);
        checkOutput("rstBusError", bus_error, 0);
        checkOutput("rstStall", stall, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Zero-wait word store.
        storeOp(1'b0, 16'h1234, 16'hBEEF, 2'b11, 0);
        // Stall is combinational on a fresh request.
        applyStimulus(1'b0, 1'b1, 16'h0101, 16'h0000, 2'b10, 1'b1, 4'd7);
        #1;
        checkOutput("stallComb", stall, 1);
        clearRequest();
        #1;
        checkOutput("stallCombDrop", stall, 0);
        @(posedge CLK); #1;

        // Byte loads: high lane signed, low lane unsigned/signed, word with waits.
        loadOp(16'h0101, 2'b10, 1'b1, 4'd7, 16'h80FF, 16'hFF80, 2, 0);
        loadOp(16'h0010, 2'b01, 1'b0, 4'd3, 16'h1280, 16'h0080, 0, 0);
        loadOp(16'h0010, 2'b01, 1'b1, 4'd4, 16'h1280, 16'hFF80, 0, 1);
        loadOp(16'h0020, 2'b11, 1'b1, 4'd6, 16'h8001, 16'h8001, 1, 2);

        // Load never accepted: four REQ cycles, then error plus zero writeback.
        applyStimulus(1'b0, 1'b1, 16'h0300, 16'h0000, 2'b11, 1'b0, 4'd9);
        @(posedge CLK); #1;
        clearRequest();
        w.dreg = 4'd9; w.data = 16'h0000;
        expWb.push_back(w);
        for (int i = 0; i < 4; i++) begin
            checkOutput("toValid", busIf.bus_valid, 1);
            checkOutput("toStall", stall, 1);
            @(posedge CLK); #1;
        end
        errExpected = 1'b1;
        checkOutput("toBusError", bus_error, 1);
        checkOutput("toWbValid", wb_valid, 1);
        checkOutput("toWbData", wb_data, 16'h0000);
        checkOutput("toIdleValid", busIf.bus_valid, 0);
        @(posedge CLK); #1;
        errExpected = 1'b0;
        checkOutput("toErrorDone", bus_error, 0);
        checkOutput("toStallDone", stall, 0);

        // Store and load together: only the write goes out.
        storeOp(1'b1, 16'h0200, 16'h5A5A, 2'b11, 1);

        // Reset while waiting for read data.
        applyStimulus(1'b0, 1'b1, 16'h0400, 16'h0000, 2'b11, 1'b0, 4'd5);
        @(posedge CLK); #1;
        clearRequest();
        e.wr = 1'b0; e.addr = 16'h0400; e.wdata = 16'h0000; e.mask = 2'b11;
        expBus.push_back(e);
        busIf.bus_ready = 1'b1;
        @(posedge CLK); #1;
        busIf.bus_ready = 1'b0;
        checkOutput("rdWaitStall", stall, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checkOutput("midRstValid", busIf.bus_valid, 0);
        checkOutput("midRstStall", stall, 0);
        checkOutput("midRstWb", wb_valid, 0);
        checkOutput("midRstErr", bus_error, 0);
        busIf.bus_rdata  = 16'h1111;
        busIf.bus_rvalid = 1'b1;
        @(posedge CLK); #1;
        busIf.bus_rvalid = 1'b0;
        checkOutput("idleRvalidNoWb", wb_valid, 0);
        checkOutput("idleRvalidNoReq", busIf.bus_valid, 0);
        @(posedge CLK); #1;
        checkOutput("idleRvalidNoWb2", wb_valid, 0);

        // Back-to-back zero-wait store then load.
        applyStimulus(1'b1, 1'b0, 16'h0500, 16'hCAFE, 2'b01, 1'b0, 4'd1);
        @(posedge CLK); #1;
        t1 = cycleCount;
        checkOutput("b2bFirstValid", busIf.bus_valid, 1);
        e.wr = 1'b1; e.addr = 16'h0500; e.wdata = 16'hCAFE; e.mask = 2'b01;
        expBus.push_back(e);
        applyStimulus(1'b0, 1'b1, 16'h0600, 16'h0000, 2'b11, 1'b0, 4'd8);
        busIf.bus_ready = 1'b1;
        @(posedge CLK); #1;
        busIf.bus_ready = 1'b0;
        checkOutput("b2bGapValid", busIf.bus_valid, 0);
        checkOutput("b2bGapStall", stall, 1);
        @(posedge CLK); #1;
        t2 = cycleCount;
        clearRequest();
        checkOutput("b2bSecondValid", busIf.bus_valid, 1);
        checkOutput("b2bSpacing", t2 - t1, 2);
        e.wr = 1'b0; e.addr = 16'h0600; e.wdata = 16'h0000; e.mask = 2'b11;
        expBus.push_back(e);
        busIf.bus_ready = 1'b1;
        @(posedge CLK); #1;
        busIf.bus_ready = 1'b0;
        busIf.bus_rdata  = 16'h7E57;
        busIf.bus_rvalid = 1'b1;
        w.dreg = 4'd8; w.data = 16'h7E57;
        expWb.push_back(w);
        @(posedge CLK); #1;
        busIf.bus_rvalid = 1'b0;
        checkOutput("b2bWbValid", wb_valid, 1);
        @(posedge CLK); #1;

        checkOutput("busQueueEmpty", expBus.size(), 0);
        checkOutput("wbQueueEmpty", expWb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
